// File: rtl/barrel_shift_pkg.sv
// Shared shift-op encoding and decode helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    ROR = 2'b00,
    ROL = 2'b01,
    SRL = 2'b10,
    SRA = 2'b11
  } shift_op_t;

  function automatic logic is_right(input shift_op_t op);
    return op != ROL;
  endfunction

  function automatic logic is_rotate(input shift_op_t op);
    return (op == ROR) || (op == ROL);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One barrel-shifter level: conditional shift by DIST plus the registered payload.
// The carry port exists only when BARREL_SHIFT_CARRY_EN is defined.
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DIST  = 1,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [1:0]       up_op,
  input  logic [SHW-1:0]   up_amt,
  input  logic [TAG_W-1:0] up_tag,
`ifdef BARREL_SHIFT_CARRY_EN
  input  logic             up_carry,
  output logic             dn_carry,
`endif
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic [1:0]       dn_op,
  output logic [SHW-1:0]   dn_amt,
  output logic [TAG_W-1:0] dn_tag
);

  localparam int unsigned BIT = $clog2(DIST);

  shift_op_t        op_c;
  logic [WIDTH-1:0] shifted_c;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
`ifdef BARREL_SHIFT_CARRY_EN
  logic             carry_q, carry_d;
`endif

  // Single-level shift; SRA replicates the current MSB so the sign survives every level.
  always_comb begin
    op_c = shift_op_t'(up_op);
    if (is_rotate(op_c)) begin
      shifted_c = is_right(op_c) ? ((up_data >> DIST) | (up_data << (WIDTH - DIST)))
                                 : ((up_data << DIST) | (up_data >> (WIDTH - DIST)));
    end else if (op_c == SRA) begin
      shifted_c = WIDTH'($signed(up_data) >>> DIST);
    end else begin
      shifted_c = up_data >> DIST;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    amt_d   = amt_q;
    tag_d   = tag_q;
`ifdef BARREL_SHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    if (adv) begin
      valid_d = up_valid;
      data_d  = up_amt[BIT] ? shifted_c : up_data;
      op_d    = up_op;
      amt_d   = up_amt;
      tag_d   = up_tag;
`ifdef BARREL_SHIFT_CARRY_EN
      if (up_amt[BIT]) begin
        carry_d = is_rotate(op_c) ? 1'b0 : up_data[DIST-1];
      end else begin
        carry_d = up_carry;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      tag_q   <= '0;
`ifdef BARREL_SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      tag_q   <= tag_d;
`ifdef BARREL_SHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_op    = op_q;
  assign dn_amt   = amt_q;
  assign dn_tag   = tag_q;
`ifdef BARREL_SHIFT_CARRY_EN
  assign dn_carry = carry_q;
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter (ROR/ROL/SRL/SRA), one register per level,
// valid/ready on both sides. Define BARREL_SHIFT_CARRY_EN to add out_carry.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef BARREL_SHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic             v_s   [SHW+1];
  logic [WIDTH-1:0] d_s   [SHW+1];
  logic [1:0]       op_s  [SHW+1];
  logic [SHW-1:0]   amt_s [SHW+1];
  logic [TAG_W-1:0] tag_s [SHW+1];
`ifdef BARREL_SHIFT_CARRY_EN
  logic             c_s   [SHW+1];
`endif
  logic [SHW-1:0]   adv_c;
  logic             unused_tail;

  assign v_s[0]   = in_valid;
  assign d_s[0]   = in_data;
  assign op_s[0]  = in_op;
  assign amt_s[0] = in_amt;
  assign tag_s[0] = in_tag;
`ifdef BARREL_SHIFT_CARRY_EN
  assign c_s[0]   = 1'b0;
`endif

  // A stage advances if it or any stage downstream has a bubble, or the consumer takes the result.
  always_comb begin
    adv_c = '0;
    for (int k = 0; k < int'(SHW); k++) begin
      adv_c[k] = out_ready;
      for (int j = 0; j < int'(SHW); j++) begin
        if (j >= k && !v_s[j+1]) adv_c[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < int'(SHW); k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .DIST (32'(1) << k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv_c[k]),
      .up_valid(v_s[k]),
      .up_data (d_s[k]),
      .up_op   (op_s[k]),
      .up_amt  (amt_s[k]),
      .up_tag  (tag_s[k]),
`ifdef BARREL_SHIFT_CARRY_EN
      .up_carry(c_s[k]),
      .dn_carry(c_s[k+1]),
`endif
      .dn_valid(v_s[k+1]),
      .dn_data (d_s[k+1]),
      .dn_op   (op_s[k+1]),
      .dn_amt  (amt_s[k+1]),
      .dn_tag  (tag_s[k+1])
    );
  end

  assign in_ready    = adv_c[0];
  assign out_valid   = v_s[SHW];
  assign out_data    = d_s[SHW];
  assign out_tag     = tag_s[SHW];
  assign unused_tail = ^{op_s[SHW], amt_s[SHW]};
`ifdef BARREL_SHIFT_CARRY_EN
  assign out_carry   = c_s[SHW];
`endif

endmodule
